// File: rtl/addbit_serial_ctrl_pkg.sv
// addbit_serial_ctrl_pkg
//   Shared constants for the bit-serial adder/subtractor controller.
//   FSM state encoding and the operation select values driven on 'sub'.
package addbit_serial_ctrl_pkg;

    // FSM states (2-bit, kept as plain constants for legacy tools)
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Operation select
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addbit.sv
// addbit
//   Existing 1-bit full adder cell, purely combinational.
//   Ports: a, b, cin  - addend bits and carry in
//          s, cout    - sum bit and carry out
module addbit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/addbit_serial_ctrl.sv
// addbit_serial_ctrl
//   Bit-serial adder/subtractor. One shared addbit cell is stepped over
//   WIDTH cycles, LSB first, with the carry held in a flop between cycles.
//   Ports:
//     clk, rst_n      - clock, asynchronous active-low reset
//     start, sub      - request and operation (0 = a+b, 1 = a-b), sampled in IDLE
//     a, b            - operands, sampled with start
//     busy            - high while bits are being processed
//     done            - one-cycle pulse, result valid
//     sum, cout, ovf  - result, final carry (sub: 1 = no borrow), signed overflow
module addbit_serial_ctrl
    import addbit_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic             bit_s;
    logic             bit_co;

    addbit u_addbit (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (bit_s),
        .cout (bit_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b, seed carry with 1
                        a_sr   <= a;
                        b_sr   <= (sub == OP_SUB) ? ~b : b;
                        carry  <= sub;
                        cnt    <= '0;
                        res_sr <= '0;
                        cout_r <= 1'b0;
                        ovf_r  <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {bit_s, res_sr[WIDTH-1:1]};
                    carry  <= bit_co;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        // carry currently holds the carry into the MSB
                        cout_r <= bit_co;
                        ovf_r  <= carry ^ bit_co;
                        state  <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign sum  = res_sr;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_addbit_serial_ctrl.sv
// tb_addbit_serial_ctrl
//   Directed bench for addbit_serial_ctrl (WIDTH = 8). Stimulus pushes the
//   hand-computed result plus the cycle at which done must appear; a monitor
//   pops and compares whenever done is high.
module tb_addbit_serial_ctrl;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               done_cyc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    exp_t q[$];
    int   checks;
    int   errors;
    int   cyc;
    int   busy_run;

    addbit_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d, sum %0h)", cyc, sum);
                end else begin
                    e = q.pop_front();
                    check("sum", 32'(sum), 32'(e.sum));
                    check("cout", 32'(cout), 32'(e.cout));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    check("done_latency", 32'(cyc), 32'(e.done_cyc));
                    check("busy_cycles", 32'(busy_run), 32'(WIDTH));
                end
                busy_run = 0;
            end
        end
    end

    // One-cycle start pulse; optionally registers the expected result
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic isub, input bit push,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        a     = ia;
        b     = ib;
        sub   = isub;
        start = 1'b1;
        if (push) begin
            e.sum      = es;
            e.cout     = ec;
            e.ovf      = eo;
            e.done_cyc = cyc + 1 + WIDTH;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a     = '1;
        b     = '1;
        sub   = 1'b0;
    endtask

    // Returns at the falling edge where done is seen high
    task automatic wait_done(input string name);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        busy_run = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        sub    = 1'b0;
        a      = '0;
        b      = '0;

        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_ovf", 32'(ovf), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Additions
        issue(8'h3C, 8'h05, 1'b0, 1, 8'h41, 1'b0, 1'b0); wait_done("add_3c_05");
        issue(8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1, 1'b0); wait_done("add_ff_01");
        issue(8'h7F, 8'h01, 1'b0, 1, 8'h80, 1'b0, 1'b1); wait_done("add_7f_01");
        // Subtractions
        issue(8'h05, 8'h07, 1'b1, 1, 8'hFE, 1'b0, 1'b0); wait_done("sub_05_07");
        issue(8'h80, 8'h01, 1'b1, 1, 8'h7F, 1'b1, 1'b1); wait_done("sub_80_01");

        // Second start while busy is ignored
        issue(8'h11, 8'h22, 1'b0, 1, 8'h33, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start");
        repeat (5) @(negedge clk);
        check("hold_sum", 32'(sum), 32'h33);
        check("hold_busy", 32'(busy), 0);

        // Reset in the middle of RUN
        issue(8'hFF, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_sum", 32'(sum), 0);
        check("abort_cout", 32'(cout), 0);
        check("abort_ovf", 32'(ovf), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(8'h12, 8'h34, 1'b0, 1, 8'h46, 1'b0, 1'b0); wait_done("after_abort");

        // Back-to-back: second start in the cycle right after done
        issue(8'h01, 8'h01, 1'b0, 1, 8'h02, 1'b0, 1'b0); wait_done("b2b_1");
        issue(8'h00, 8'h01, 1'b1, 1, 8'hFF, 1'b0, 1'b0); wait_done("b2b_2");

        repeat (5) @(negedge clk);
        check("pending_results", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addbit_serial_ctrl.md
Name: addbit_serial_ctrl

Overview:
Bit-serial adder/subtractor controller that sequences a single 1-bit full adder (addbit) over WIDTH clock cycles to produce a WIDTH-bit sum or difference.
It latches operands on a start handshake, feeds one bit pair per cycle LSB-first through the shared addbit instance, and registers the carry between cycles.
It reports the result, carry-out and signed overflow with a one-cycle done pulse.
It is the sequencing layer above the existing addbit cell and trades latency for one full-adder of area.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2).
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only in IDLE
sub    input   1      0 = a+b, 1 = a-b; sampled with start
a      input   WIDTH  operand A; sampled with start
b      input   WIDTH  operand B; sampled with start
busy   output  1      high while in RUN
done   output  1      one-cycle pulse: result valid
sum    output  WIDTH  result; held stable from done until next accepted start
cout   output  1      final carry out (sub: 1 = no borrow)
ovf    output  1      two's-complement overflow

Behaviour:
- Reset (rst_n low, async):
  - State = IDLE.
  - busy, done, cout and ovf = 0; sum = 0.
  - Operand shift registers, carry flop and counter = 0.
- Reset mid-RUN aborts the operation. No done is produced for it.
- IDLE:
  - On the rising edge with start = 1, latch a_sr = a and b_sr = (sub ? ~b : b).
  - carry = sub; cnt = 0; go to RUN.
- RUN (busy = 1):
  - Each cycle the addbit inputs are a = a_sr[0], b = b_sr[0], cin = carry.
  - At each edge:
    - a_sr and b_sr shift right by 1.
    - The result shift register shifts right with s entering at bit WIDTH-1.
    - carry <= addbit cout.
    - cnt++.
  - On the edge where cnt == WIDTH-1 (the last bit):
    - Capture cin_msb = carry (the carry into the MSB), so ovf = cin_msb XOR cout_final.
    - Go to DONE.
- DONE: lasts exactly one cycle.
  - done = 1, busy = 0.
  - sum, cout and ovf are valid, then go to IDLE.
  - sum, cout and ovf hold until the next accepted start, then clear to 0 at that edge.
- Latency: start accepted at edge k gives busy = 1 for cycles k+1 .. k+WIDTH and done = 1 in cycle k+WIDTH+1. The next start is accepted at edge k+WIDTH+2 at the earliest.
- start is ignored while busy or done. No queuing, no error flag.
- Operand changes after the accepting edge have no effect.
- Wrap-around is modulo 2^WIDTH. Carry or borrow is reported only via cout.
- Subtraction is a + ~b + 1, so cout = 1 means a >= b unsigned.

Decomposition:
- Shared package holds:
  - State encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - OP_ADD = 1'b0, OP_SUB = 1'b1.
- One sub-module: the existing addbit, instantiated once, combinational.
- Shift registers, counter and FSM live in addbit_serial_ctrl itself.

Test Plan:
- WIDTH=8, add 0x3C+0x05 -> sum=0x41, cout=0, ovf=0; done exactly 9 cycles after the start edge; busy high 8 cycles.
- Add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0; add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
- Sub 0x05-0x07 -> sum=0xFE, cout=0, ovf=0; sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
- Pulse start with a=0x11, b=0x22, then pulse start again 3 cycles later with a=0xAA, b=0xAA -> only one done, sum=0x33; the second request is ignored; sum holds 0x33 until the next IDLE start.
- Drop rst_n low 4 cycles into RUN -> busy, done, sum, cout and ovf go 0 immediately (async); no done follows. A new start after release completes normally.
- Back-to-back: assert start in the cycle after done (0x01+0x01, then sub 0x00-0x01) -> 0x02 and cout=0, then 0xFF with cout=0, ovf=0; each done is spaced WIDTH+2 cycles apart.
